ahblite_slave_mux: RTL

- Response-side companion to the AHB-Lite address decoder: takes the decoder's one-hot HSEL_A in the address phase, registers it into the data phase, and returns the selected slave's HREADYOUT/HRDATA/HRESP to the single master.
- Contains the built-in default slave that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR response.
- Sits between the 8 slave ports (RAMCODE, RAMDATA, GPIO, UART, HDMI, spares) and the Cortex-M0 master.

---
 rtl/ahblite_slave_mux_if.sv | 24 ++
 rtl/ahblite_slave_mux.sv | 115 +++++++++++
 2 files changed

// File: rtl/ahblite_slave_mux_if.sv
// rtl/ahblite_slave_mux_if.sv - AHB-Lite response-side bus bundle between decoder/slaves, mux and master
interface ahblite_slave_mux_if #(
  parameter int NSLV = 8
);
  logic [NSLV-1:0]      HSEL_A;
  logic [1:0]           HTRANS;
  logic [NSLV-1:0]      HREADYOUT_S;
  logic [NSLV-1:0]      HRESP_S;
  logic [32*NSLV-1:0]   HRDATA_S;
  logic                 HREADY;
  logic                 HRESP;
  logic [31:0]          HRDATA;
  logic                 TIMEOUT_FLAG;

  modport slave (
    input  HSEL_A, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HREADY, HRESP, HRDATA, TIMEOUT_FLAG
  );

  modport master (
    output HSEL_A, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HREADY, HRESP, HRDATA, TIMEOUT_FLAG
  );
endinterface

// File: rtl/ahblite_slave_mux.sv
// rtl/ahblite_slave_mux.sv - AHB-Lite slave response mux with built-in default ERROR slave
// Optional macro AHB_MUX_TIMEOUT_EN adds a wait-state watchdog and sticky TIMEOUT_FLAG.
module ahblite_slave_mux #(
  parameter int          NSLV           = 8,
  parameter logic [31:0] DEF_RDATA      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input logic                HCLK,
  input logic                HRESET,
  ahblite_slave_mux_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } dstate_t;

  logic [NSLV-1:0] sel_q;
  dstate_t         dstate;
  logic            sel_ready;
  logic            sel_resp;
  logic [31:0]     sel_rdata;
  logic            ready;
  logic            resp;
  logic [31:0]     rdata;
  logic            active;
  logic            force_err;

  assign active = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);

  // Descending scan so the lowest set bit wins on an illegal multi-hot select.
  always_comb begin
    sel_ready = 1'b1;
    sel_resp  = 1'b0;
    sel_rdata = DEF_RDATA;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (sel_q[i]) begin
        sel_ready = bus.HREADYOUT_S[i];
        sel_resp  = bus.HRESP_S[i];
        sel_rdata = bus.HRDATA_S[32*i +: 32];
      end
    end
  end

  always_comb begin
    ready = sel_ready;
    resp  = sel_resp;
    rdata = sel_rdata;
    case (dstate)
      ERR1: begin
        ready = 1'b0;
        resp  = 1'b1;
        rdata = DEF_RDATA;
      end
      ERR2: begin
        ready = 1'b1;
        resp  = 1'b1;
        rdata = DEF_RDATA;
      end
      default: ;
    endcase
  end

`ifdef AHB_MUX_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_flag;
  logic        stalled;

  assign stalled   = (dstate == IDLE) && (sel_q != '0) && !sel_ready;
  assign force_err = stalled && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait_cnt     <= 16'd0;
      timeout_flag <= 1'b0;
    end else if (ready) begin
      wait_cnt <= 16'd0;
    end else if (force_err) begin
      wait_cnt     <= 16'd0;
      timeout_flag <= 1'b1;
    end else if (stalled) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign bus.TIMEOUT_FLAG = timeout_flag;
`else
  assign force_err        = 1'b0;
  assign bus.TIMEOUT_FLAG = 1'b0;
`endif

  // A forced timeout leaves sel_q stale; ERR1/ERR2 outrank it and ERR2 reloads it.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q  <= '0;
      dstate <= IDLE;
    end else begin
      case (dstate)
        ERR1: dstate <= ERR2;
        default: begin
          if (force_err) begin
            dstate <= ERR1;
          end else if (ready) begin
            sel_q  <= bus.HSEL_A;
            dstate <= ((bus.HSEL_A == '0) && active) ? ERR1 : IDLE;
          end
        end
      endcase
    end
  end

  assign bus.HREADY = ready;
  assign bus.HRESP  = resp;
  assign bus.HRDATA = rdata;
endmodule
